// File: rtl/folded_packet_receiver.sv
// Folded-flit packet receiver: reassembles header+payload packets into a packet FIFO.
// Optional frame checking enabled by defining RECEIVER_FRAME_CHECK_EN.
module folded_packet_receiver #(
    parameter int FLIT_WIDTH = 8,
    parameter int GATE_WIDTH = 4,
    parameter int GATE_FOLDS = 2,
    parameter int DEPTH      = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_enable,
    input  logic [FLIT_WIDTH*GATE_FOLDS-1:0] i_rx,
    input  logic                             i_pull,
    output logic                             o_available,
    output logic [GATE_WIDTH-1:0]            o_vl,
    output logic [GATE_WIDTH-1:0]            o_cr,
    output logic [FLIT_WIDTH*GATE_WIDTH-1:0] o_dt,
    output logic [$clog2(DEPTH+1)-1:0]       o_count,
    output logic                             o_drop
);
    localparam int FW   = FLIT_WIDTH;
    localparam int GW   = GATE_WIDTH;
    localparam int GF   = GATE_FOLDS;
    localparam int RW   = FW * GF;
    localparam int DW   = FW * GW;
    localparam int HS   = 1 + 2 * GW;
    localparam int HF   = (HS + FW - 1) / FW;
    localparam int HB   = HF * FW;
    localparam int PADW = HB - HS;
    localparam int HCW  = $clog2(HF + 1);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam logic [HB-1:0] PAD_MASK = HB'((64'd1 << PADW) - 64'd1);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t          state_q, state_d;
    logic [HCW-1:0]  cnt_q, cnt_d;
    logic [HB-1:0]   hdr_q, hdr_d;
    logic [GW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [FW-1:0]   flit;
    logic            fin, skip, found;
    logic            chk_en, bad, idle_err;

`ifdef RECEIVER_FRAME_CHECK_EN
    assign chk_en = 1'b1;
`else
    assign chk_en = 1'b0;
`endif

    // Walk the lanes earliest-first; once the packet finishes the rest are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        rem_d   = rem_q;
        dat_d   = dat_q;
        flit    = '0;
        fin     = 1'b0;
        skip    = 1'b0;
        found   = 1'b0;
        if (i_enable) begin
            if (state_q == IDLE) begin
                if (i_rx[RW-1]) begin
                    state_d = HDR;
                    cnt_d   = '0;
                    hdr_d   = '0;
                    rem_d   = '0;
                    dat_d   = '0;
                end else begin
                    skip = 1'b1;
                end
            end
            for (int k = 0; k < GF; k++) begin
                flit = i_rx[(GF-1-k)*FW +: FW];
                if (state_d == HDR) begin
                    hdr_d = (hdr_d << FW) | HB'(flit);
                    cnt_d = cnt_d + 1'b1;
                    if (cnt_d == HCW'(HF)) begin
                        rem_d = hdr_d[HB-2 -: GW];
                        if (rem_d == '0) begin
                            fin     = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = PAY;
                        end
                    end
                end else if (state_d == PAY) begin
                    found = 1'b0;
                    for (int g = 0; g < GW; g++) begin
                        if (rem_d[g] && !found) begin
                            found               = 1'b1;
                            rem_d[g]            = 1'b0;
                            dat_d[g*FW +: FW]   = flit;
                        end
                    end
                    if (rem_d == '0) begin
                        fin     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        end
        bad      = chk_en & (|(hdr_d & PAD_MASK));
        idle_err = chk_en & skip;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            rem_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            rem_q   <= rem_d;
            dat_q   <= dat_d;
        end
    end

    logic [GW-1:0] vl_mem [DEPTH];
    logic [GW-1:0] cr_mem [DEPTH];
    logic [DW-1:0] dt_mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count_q;
    logic [GW-1:0] new_vl, new_cr;
    logic          full, pop, wr;

    assign new_vl      = hdr_d[HB-2 -: GW];
    assign new_cr      = hdr_d[HB-2-GW -: GW];
    assign o_available = (count_q != '0);
    assign o_count     = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign pop         = o_available & i_pull;
    assign wr          = fin & ~bad & (~full | pop);
    assign rd_nxt      = rd_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (wr) begin
            vl_mem[wr_ptr] <= new_vl;
            cr_mem[wr_ptr] <= new_cr;
            dt_mem[wr_ptr] <= dat_d;
        end
    end

    // Head registers: refilled from the entry behind, or from the commit bypass.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            o_drop  <= 1'b0;
            o_vl    <= '0;
            o_cr    <= '0;
            o_dt    <= '0;
        end else begin
            o_drop  <= (fin & ~wr) | idle_err;
            count_q <= count_q + CW'(wr) - CW'(pop);
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_nxt;
                if (count_q == CW'(1)) begin
                    o_vl <= wr ? new_vl : '0;
                    o_cr <= wr ? new_cr : '0;
                    o_dt <= wr ? dat_d : '0;
                end else begin
                    o_vl <= vl_mem[rd_nxt];
                    o_cr <= cr_mem[rd_nxt];
                    o_dt <= dt_mem[rd_nxt];
                end
            end else if (!o_available && wr) begin
                o_vl <= new_vl;
                o_cr <= new_cr;
                o_dt <= dat_d;
            end
        end
    end
endmodule
